// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and oversampling ratio.
// The receiver reuses both, so keep them here rather than in either module.
package uart_pkg;

  // Ticks per serial bit; baud_gen runs at 16x the bit rate.
  localparam int OversampleTicks = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DataBits data bits LSB first, optional even
// parity bit, then StopTicks ticks of stop level. Bit timing comes from the
// 16x tick strobe of baud_gen; tx_o is registered straight to the pad.
//
// Handshake: tx_start_i is a valid strobe with din_i as its payload. The
// transmitter is ready exactly when tx_busy_o is low (IDLE and not in the
// done cycle); a word transfers on any clock where valid and ready are both
// high. A request while not ready is dropped, never queued, and din_i is
// only sampled on the transfer clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DataBits  = 8,
  parameter int StopTicks = 16,
  parameter bit ParityEn  = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                tx_start_i,
  input  logic [DataBits-1:0] din_i,
  output logic                tx_o,
  output logic                tx_busy_o,
  output logic                tx_done_o,
  output tx_state_t           state_o
);

  // The tick counter must also reach StopTicks-1 while in STOP.
  localparam int TickW = (StopTicks > OversampleTicks) ? $clog2(StopTicks)
                                                       : $clog2(OversampleTicks);
  localparam int BitW  = $clog2(DataBits);

  localparam logic [TickW-1:0] BitLast  = TickW'(OversampleTicks - 1);
  localparam logic [TickW-1:0] StopLast = TickW'(StopTicks - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DataBits - 1);

  tx_state_t           state_q;
  logic [TickW-1:0]    tick_cnt;
  logic [BitW-1:0]     bit_cnt;
  logic [DataBits-1:0] shift_q;
  logic                parity_q;

  assign state_o = state_q;

  // Frame sequencer: every output is registered, so the line changes on the
  // edge after the tick that ends a bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_o      <= 1'b1;
      tx_busy_o <= 1'b0;
      tx_done_o <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_o <= 1'b1;
          // Busy covers the done cycle, so requests in that cycle are dropped.
          if (tx_done_o) begin
            tx_busy_o <= 1'b0;
          end else if (tx_start_i) begin
            shift_q   <= din_i;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            parity_q  <= 1'b0;
            tx_o      <= 1'b0;
            tx_busy_o <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (tick_i) begin
            if (tick_cnt == BitLast) begin
              tick_cnt <= '0;
              tx_o     <= shift_q[0];
              state_q  <= DATA;
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
        end
        DATA: begin
          if (tick_i) begin
            if (tick_cnt == BitLast) begin
              tick_cnt <= '0;
              shift_q  <= shift_q >> 1;
              parity_q <= parity_q ^ shift_q[0];
              if (bit_cnt == DataLast) begin
                if (ParityEn) begin
                  tx_o    <= parity_q ^ shift_q[0];
                  state_q <= PARITY;
                end else begin
                  tx_o    <= 1'b1;
                  state_q <= STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + BitW'(1);
                tx_o    <= shift_q[1];
              end
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
        end
        PARITY: begin
          if (tick_i) begin
            if (tick_cnt == BitLast) begin
              tick_cnt <= '0;
              tx_o     <= 1'b1;
              state_q  <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
        end
        STOP: begin
          if (tick_i) begin
            if (tick_cnt == StopLast) begin
              tick_cnt  <= '0;
              tx_o      <= 1'b1;
              tx_done_o <= 1'b1;
              state_q   <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
        end
        default: begin
          tx_o    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
